// File: rtl/mem_arb_pkg.sv
// Shared definitions for the fetch/data memory arbiter: FSM state codes, RISC-V
// load/store funct3 codes, default data-port offset and a funct3 legality helper.
package mem_arb_pkg;

    localparam int DATA_OFFSET_DEF = 255;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE  = 2'b00;
    localparam arb_state_t ST_FETCH = 2'b01;
    localparam arb_state_t ST_DATA  = 2'b10;
    localparam arb_state_t ST_RESP  = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    function automatic logic f3_legal(input logic [2:0] func);
        case (func)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: f3_legal = 1'b1;
            default:                             f3_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_ext.sv
// Load extender: picks byte/half/word from the top of the memory word and
// sign- or zero-extends it; unsupported funct3 codes yield zero.
module mem_arb_ext import mem_arb_pkg::*; (
    input  logic [2:0]  func,
    input  logic [31:0] rdata,
    output logic [31:0] ext
);

    // select and extend the load data by funct3
    always_comb begin
        ext = 32'h0000_0000;
        case (func)
            F3_LB:   ext = {{24{rdata[31]}}, rdata[31:24]};
            F3_LH:   ext = {{16{rdata[31]}}, rdata[31:16]};
            F3_LW:   ext = rdata;
            F3_LBU:  ext = {24'h00_0000, rdata[31:24]};
            F3_LHU:  ext = {16'h0000, rdata[31:16]};
            default: ext = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-ported memory, one access per two
// cycles. Define ARB_FAIR_EN to let fetch win the arbitration after a data access.
module mem_arbiter import mem_arb_pkg::*; #(
    parameter int ADDR_W      = 9,
    parameter int DATA_OFFSET = DATA_OFFSET_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_func,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_valid,
    output logic              stall_if,
    output logic              mem_read,
    output logic              mem_write,
    output logic [2:0]        mem_func,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    arb_state_t        state_r;
    arb_state_t        state_nxt_s;
    logic              grant_d_r;
    logic              grant_d_nxt_s;
    logic [2:0]        func_r;
    logic [31:0]       if_rdata_r;
    logic [31:0]       d_rdata_r;
    logic [31:0]       ext_s;
    logic [ADDR_W-1:0] d_addr_off_s;
    logic              fetch_first_s;
    logic              unused_s;

    assign unused_s     = ^{if_addr[31:ADDR_W], d_addr[31:ADDR_W]};
    assign d_addr_off_s = d_addr[ADDR_W-1:0] + ADDR_W'(DATA_OFFSET);

`ifdef ARB_FAIR_EN
    logic last_d_r;

    // remember whether the most recent completion was a data access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d_r <= 1'b0;
        end else if (state_r == ST_RESP) begin
            last_d_r <= grant_d_r;
        end else begin
            last_d_r <= last_d_r;
        end
    end

    // in RESP the completing access is not yet in last_d_r, so look at the grant
    assign fetch_first_s = if_req & ((state_r == ST_RESP) ? grant_d_r : last_d_r);
`else
    assign fetch_first_s = 1'b0;
`endif

    // arbitration and sequencing; RESP arbitrates like IDLE so accesses can chain
    always_comb begin
        state_nxt_s   = state_r;
        grant_d_nxt_s = grant_d_r;
        case (state_r)
            ST_IDLE, ST_RESP: begin
                if (d_req && !fetch_first_s) begin
                    state_nxt_s   = ST_DATA;
                    grant_d_nxt_s = 1'b1;
                end else if (if_req) begin
                    state_nxt_s   = ST_FETCH;
                    grant_d_nxt_s = 1'b0;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_FETCH, ST_DATA: state_nxt_s = ST_RESP;
            default:           state_nxt_s = ST_IDLE;
        endcase
    end

    // state, granted port and the funct3 captured for the response cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            grant_d_r <= 1'b0;
            func_r    <= 3'b000;
        end else begin
            state_r   <= state_nxt_s;
            grant_d_r <= grant_d_nxt_s;
            func_r    <= (state_r == ST_DATA) ? d_func : func_r;
        end
    end

    // hold the last returned words between valid pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rdata_r <= 32'h0000_0000;
            d_rdata_r  <= 32'h0000_0000;
        end else begin
            if (if_valid) if_rdata_r <= mem_rdata;
            if (d_valid)  d_rdata_r  <= ext_s;
        end
    end

    mem_arb_ext u_ext (
        .func  (func_r),
        .rdata (mem_rdata),
        .ext   (ext_s)
    );

    assign if_valid = (state_r == ST_RESP) & ~grant_d_r;
    assign d_valid  = (state_r == ST_RESP) &  grant_d_r;
    assign if_rdata = if_valid ? mem_rdata : if_rdata_r;
    assign d_rdata  = d_valid  ? ext_s     : d_rdata_r;
    assign stall_if = if_req & ~if_valid;

    // memory-side drive; illegal funct3 codes still complete but never strobe
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_func  = 3'b000;
        mem_addr  = '0;
        mem_wdata = 32'h0000_0000;
        case (state_r)
            ST_FETCH: begin
                mem_read = 1'b1;
                mem_func = F3_LW;
                mem_addr = if_addr[ADDR_W-1:0];
            end
            ST_DATA: begin
                mem_func  = {1'b0, d_func[1:0]};
                mem_addr  = d_addr_off_s;
                mem_wdata = d_wdata;
                if (f3_legal(d_func)) begin
                    mem_write = d_we;
                    mem_read  = ~d_we;
                end else begin
                    mem_write = 1'b0;
                    mem_read  = 1'b0;
                end
            end
            default: begin
                mem_read = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic checked cycle by cycle against a transaction-timeline model.
module tb_mem_arbiter;

    localparam int ADDR_W      = 9;
    localparam int DATA_OFFSET = 255;
`ifdef ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req, d_req, d_we;
    logic [31:0]       if_addr, d_addr, d_wdata, mem_rdata;
    logic [2:0]        d_func;
    logic [31:0]       if_rdata, d_rdata, mem_wdata;
    logic              if_valid, d_valid, stall_if, mem_read, mem_write;
    logic [2:0]        mem_func;
    logic [ADDR_W-1:0] mem_addr;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_OFFSET(DATA_OFFSET)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_func(d_func), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .stall_if(stall_if),
        .mem_read(mem_read), .mem_write(mem_write), .mem_func(mem_func),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // reference model: a timeline of granted transactions
    int          cyc;
    int          next_arb, strobe_cyc, valid_cyc;
    bit          t_is_d, t_we, last_d;
    logic [2:0]  t_func;
    logic [31:0] t_addr, t_wdata;
    logic [31:0] exp_if_rdata, exp_d_rdata;
    bit          d_granted, if_granted;
    bit          fix_en;
    logic [31:0] fix_val;

    function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [31:0] w);
        int unsigned b, h;
        b = w / 32'h0100_0000;
        h = w / 32'h0001_0000;
        case (f)
            3'd0:    return (b >= 128)   ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd2:    return w;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        next_arb     = 0;
        strobe_cyc   = -10;
        valid_cyc    = -10;
        last_d       = 1'b0;
        exp_if_rdata = 32'h0;
        exp_d_rdata  = 32'h0;
    endtask

    // decide the grant taken at the upcoming rising edge
    task automatic model_arb();
        int  e;
        bit  fetch_first;
        e = cyc + 1;
        if (e >= next_arb) begin
            fetch_first = FAIR && last_d && if_req;
            if (d_req && !fetch_first) begin
                t_is_d = 1'b1; t_we = d_we; t_func = d_func; t_addr = d_addr; t_wdata = d_wdata;
                d_granted = 1'b1;
            end else if (if_req) begin
                t_is_d = 1'b0; t_addr = if_addr;
                if_granted = 1'b1;
            end
            if (d_req || if_req) begin
                strobe_cyc = e;
                valid_cyc  = e + 1;
                next_arb   = e + 2;
                last_d     = t_is_d;
            end else begin
                next_arb = e + 1;
            end
        end
    endtask

    task automatic check_outputs();
        logic        e_rd, e_wr, e_ifv, e_dv, legal;
        logic [31:0] e_addr, e_wdata;
        logic [2:0]  e_func;
        e_rd = 1'b0; e_wr = 1'b0; e_addr = 32'h0; e_wdata = 32'h0; e_func = 3'd0;
        if (cyc == strobe_cyc) begin
            if (t_is_d) begin
                legal   = (t_func != 3'd3) && (t_func < 3'd6);
                e_addr  = (t_addr + DATA_OFFSET) % (1 << ADDR_W);
                e_func  = t_func % 4;
                e_wdata = t_wdata;
                e_rd    = legal && !t_we;
                e_wr    = legal && t_we;
            end else begin
                e_addr = t_addr % (1 << ADDR_W);
                e_func = 3'd2;
                e_rd   = 1'b1;
            end
        end
        e_ifv = (cyc == valid_cyc) && !t_is_d;
        e_dv  = (cyc == valid_cyc) && t_is_d;
        if (e_ifv) exp_if_rdata = mem_rdata;
        if (e_dv)  exp_d_rdata  = ref_load(t_func, mem_rdata);
        check_val("mem_read",  mem_read,  e_rd);
        check_val("mem_write", mem_write, e_wr);
        check_val("mem_addr",  mem_addr,  e_addr);
        check_val("mem_func",  mem_func,  e_func);
        check_val("mem_wdata", mem_wdata, e_wdata);
        check_val("if_valid",  if_valid,  e_ifv);
        check_val("d_valid",   d_valid,   e_dv);
        check_val("if_rdata",  if_rdata,  exp_if_rdata);
        check_val("d_rdata",   d_rdata,   exp_d_rdata);
        check_val("stall_if",  stall_if,  if_req && !e_ifv);
    endtask

    task automatic run_cycle();
        model_arb();
        @(posedge clk);
        cyc++;
        #1 mem_rdata = fix_en ? fix_val : $urandom();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive_random();
        if (cyc == valid_cyc) begin
            if (t_is_d) d_req = 1'b0;
            else        if_req = 1'b0;
        end
        if (d_req && !d_granted && $urandom_range(0, 9) == 0) d_req = 1'b0;
        if (if_req && !if_granted && $urandom_range(0, 9) == 0) if_req = 1'b0;
        if (!d_req && $urandom_range(0, 2) == 0) begin
            d_req = 1'b1; d_granted = 1'b0;
            d_we = 1'($urandom_range(0, 1)); d_func = 3'($urandom_range(0, 7));
            d_addr = $urandom(); d_wdata = $urandom();
        end
        if (!if_req && $urandom_range(0, 2) == 0) begin
            if_req = 1'b1; if_granted = 1'b0; if_addr = $urandom();
        end
    endtask

    initial begin
        int stalls;
        rst = 1'b1; if_req = 1'b1; d_req = 1'b0; d_we = 1'b0; d_func = 3'd0;
        if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; mem_rdata = 32'h0;
        fix_en = 1'b0; fix_val = 32'h0; d_granted = 1'b0; if_granted = 1'b0;
        t_is_d = 1'b0; t_we = 1'b0; t_func = 3'd0; t_addr = 32'h0; t_wdata = 32'h0;
        cyc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_stall_if", stall_if, 1'b1);
        check_val("rst_outputs", {mem_read, mem_write, if_valid, d_valid}, 4'b0000);
        check_val("rst_mem_addr", mem_addr, 32'h0);
        check_val("rst_rdata", if_rdata | d_rdata | mem_wdata, 32'h0);
        if_req = 1'b0; rst = 1'b0;
        model_reset();

        // fetch only
        fix_en = 1'b1; fix_val = 32'h0000_C0B7;
        if_req = 1'b1; if_addr = 32'h4;
        run_cycle();
        check_val("fetch_strobe_addr", mem_addr, 32'h4);
        run_cycle();
        check_val("fetch_valid", if_valid, 1'b1);
        check_val("fetch_rdata", if_rdata, 32'h0000_C0B7);
        if_req = 1'b0;
        run_cycle();

        // simultaneous requests: data then fetch
        d_req = 1'b1; d_we = 1'b0; d_func = 3'd2; d_addr = 32'h0;
        if_req = 1'b1; if_addr = 32'h8;
        stalls = 0;
        #1 if (stall_if) stalls++;
        run_cycle(); if (stall_if) stalls++;
        check_val("sim_first_data", {mem_read, 23'h0, mem_addr}, {1'b1, 23'h0, 9'd255});
        run_cycle(); if (stall_if) stalls++;
        check_val("sim_d_valid", d_valid, 1'b1);
        d_req = 1'b0;
        run_cycle(); if (stall_if) stalls++;
        check_val("sim_then_fetch", mem_addr, 32'h8);
        run_cycle(); if (stall_if) stalls++;
        check_val("sim_if_valid", if_valid, 1'b1);
        check_val("sim_stall_cycles", stalls, 32'd4);
        if_req = 1'b0;
        run_cycle();

        // load byte signed then unsigned
        fix_val = 32'h8012_3456;
        d_req = 1'b1; d_we = 1'b0; d_func = 3'd0; d_addr = 32'h0;
        run_cycle();
        check_val("lb_addr", mem_addr, 32'd255);
        run_cycle();
        check_val("lb_rdata", d_rdata, 32'hFFFF_FF80);
        d_func = 3'd4;
        run_cycle();
        run_cycle();
        check_val("lbu_rdata", d_rdata, 32'h0000_0080);
        d_req = 1'b0;
        run_cycle();
        check_val("lbu_hold", d_rdata, 32'h0000_0080);

        // store word
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'h1234_5678; d_func = 3'd2;
        run_cycle();
        check_val("sw_write", {mem_write, mem_read, mem_func}, 5'b10_010);
        check_val("sw_addr", mem_addr, 32'd263);
        check_val("sw_wdata", mem_wdata, 32'h1234_5678);
        run_cycle();
        check_val("sw_ack", d_valid, 1'b1);
        d_req = 1'b0; d_we = 1'b0;
        run_cycle();

        // illegal funct3
        d_req = 1'b1; d_func = 3'd7;
        run_cycle();
        check_val("ill_no_strobe", {mem_read, mem_write}, 2'b00);
        run_cycle();
        check_val("ill_valid", d_valid, 1'b1);
        check_val("ill_rdata", d_rdata, 32'h0);
        d_req = 1'b0;
        run_cycle();

        // reset during a data write
        d_req = 1'b1; d_we = 1'b1; d_func = 3'd2; d_addr = 32'h10;
        run_cycle();
        check_val("abort_pre_write", mem_write, 1'b1);
        rst = 1'b1;
        #1;
        check_val("abort_write_drop", mem_write, 1'b0);
        d_req = 1'b0; d_we = 1'b0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_val("abort_no_valid", d_valid, 1'b0);
        rst = 1'b0;
        model_reset();
        check_outputs();
        run_cycle();

        // both held: grant pattern depends on fairness
        fix_en = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_func = 3'd2; d_addr = 32'h0;
        if_req = 1'b1; if_addr = 32'h10;
        for (int k = 0; k < 4; k++) begin
            run_cycle();
            check_val("fair_grant", mem_addr, (!FAIR || (k % 2 == 0)) ? 32'd255 : 32'd16);
            run_cycle();
        end
        d_req = 1'b0; if_req = 1'b0;
        run_cycle();
        run_cycle();

        // randomized traffic
        d_granted = 1'b0; if_granted = 1'b0;
        repeat (1500) begin
            drive_random();
            run_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
